// File: rtl/gpio_port_if.sv
// gpio_port_if: data-memory bus slice seen by the GPIO peripheral.
interface gpio_port_if;
   logic        ce;
   logic        wr;
   logic [1:0]  addr;
   logic [31:0] data_in;
   logic [31:0] data_out;
   modport master (output ce, wr, addr, data_in, input data_out);
   modport slave (input ce, wr, addr, data_in, output data_out);
endinterface

// File: rtl/gpio_port.sv
// gpio_port: bidirectional GPIO with per-pin direction, 2-FF sync, debounce and rising-edge IRQ capture.
module gpio_port #(
   parameter int WIDTH = 32,
   parameter int DEBOUNCE_CYCLES = 4
) (
   input  logic             sys_clk,
   input  logic             rst_sync,
   gpio_port_if.slave       bus,
   inout  wire [WIDTH-1:0]  port_io,
   output logic             irq
);
   localparam int CW = $clog2(DEBOUNCE_CYCLES) + 1;
   localparam logic [CW-1:0] LAST = CW'(DEBOUNCE_CYCLES - 1);
   logic [WIDTH-1:0] dir, out_reg, irq_en, irq_status, sync1, sync2, debounced, settle, rise, clr;
   logic [CW-1:0] cnt [WIDTH];
   logic wr_en;
   genvar i;
   for (i = 0; i < WIDTH; i++) begin : g_pin
      assign port_io[i] = dir[i] ? out_reg[i] : 1'bz;
      assign settle[i] = (sync2[i] != debounced[i]) && (cnt[i] == LAST);
   end
   assign wr_en = bus.ce & bus.wr;
   // settle with sync2=1 means debounced is about to go 0->1
   assign rise = settle & sync2 & ~dir & irq_en;
   assign clr = (wr_en && bus.addr == 2'd3) ? bus.data_in[WIDTH-1:0] : '0;
   always_comb
      bus.data_out = (!bus.ce || bus.wr) ? 32'd0 :
                     bus.addr == 2'd0 ? 32'(dir) :
                     bus.addr == 2'd1 ? 32'((dir & out_reg) | (~dir & debounced)) :
                     bus.addr == 2'd2 ? 32'(irq_en) : 32'(irq_status);
   always_ff @(posedge sys_clk) begin
      if (!rst_sync) begin
         dir        <= '0;
         out_reg    <= '0;
         irq_en     <= '0;
         irq_status <= '0;
         sync1      <= '0;
         sync2      <= '0;
         debounced  <= '0;
         irq        <= 1'b0;
         for (int b = 0; b < WIDTH; b++) cnt[b] <= '0;
      end else begin
         sync1 <= port_io;
         sync2 <= sync1;
         for (int b = 0; b < WIDTH; b++)
            cnt[b] <= (sync2[b] == debounced[b] || settle[b]) ? '0 : cnt[b] + 1'b1;
         debounced  <= debounced ^ settle;
         irq_status <= (irq_status & ~clr) | rise;
         irq        <= |(irq_status & irq_en);
         if (wr_en && bus.addr == 2'd0) dir <= bus.data_in[WIDTH-1:0];
         if (wr_en && bus.addr == 2'd1) out_reg <= bus.data_in[WIDTH-1:0];
         if (wr_en && bus.addr == 2'd2) irq_en <= bus.data_in[WIDTH-1:0];
      end
   end
endmodule

// File: tb/tb_gpio_port.sv
// tb_gpio_port: randomized scoreboard bench for gpio_port with a sliding-window reference model.
module tb_gpio_port;
   localparam int W = 8;
   localparam int DC = 4;
   typedef struct {
      string       name;
      logic [31:0] data;
      logic        irq;
      logic [7:0]  mask;
      logic [7:0]  pins;
   } exp_t;
   logic sys_clk = 1'b0;
   logic rst_sync = 1'b0;
   logic irq;
   logic [7:0] drv = 8'h0F;
   logic [7:0] drv_en = 8'hFF;
   wire  [7:0] port_io;
   int checks = 0;
   int errors = 0;
   exp_t sb[$];
   exp_t mon_e;
   logic [7:0] m_dir = 0, m_out = 0, m_en = 0, m_st = 0, m_deb = 0;
   logic m_irq = 1'b0;
   logic [7:0] hist[$];
   gpio_port_if bus ();
   gpio_port #(.WIDTH(W), .DEBOUNCE_CYCLES(DC)) dut (
      .sys_clk(sys_clk), .rst_sync(rst_sync), .bus(bus), .port_io(port_io), .irq(irq));
   genvar i;
   for (i = 0; i < W; i++) begin : g_drv
      assign port_io[i] = drv_en[i] ? drv[i] : 1'bz;
   end
   always #5 sys_clk = ~sys_clk;

   // Reference: a pin level is accepted once the synchronised stream (pins delayed by two
   // edges) has shown the opposite of the accepted level for DC consecutive edges.
   task automatic model_edge();
      logic [7:0] pin, nd, rise, w1c;
      logic all_diff;
      if (!rst_sync) begin
         {m_dir, m_out, m_en, m_st, m_deb, m_irq} = '0;
         hist = {};
         repeat (DC + 2) hist.push_back(8'h00);
      end else begin
         pin = (m_dir & m_out) | (~m_dir & drv);
         hist.push_back(pin);
         if (hist.size() > DC + 2) void'(hist.pop_front());
         nd = m_deb;
         for (int b = 0; b < W; b++) begin
            all_diff = 1'b1;
            for (int j = 0; j < DC; j++) if (hist[j][b] == m_deb[b]) all_diff = 1'b0;
            if (all_diff) nd[b] = ~m_deb[b];
         end
         rise = nd & ~m_deb & ~m_dir & m_en;
         w1c = (bus.ce && bus.wr && bus.addr == 2'd3) ? bus.data_in[7:0] : 8'h00;
         m_irq = |(m_st & m_en);
         m_st = (m_st & ~w1c) | rise;
         m_deb = nd;
         if (bus.ce && bus.wr && bus.addr == 2'd0) m_dir = bus.data_in[7:0];
         if (bus.ce && bus.wr && bus.addr == 2'd1) m_out = bus.data_in[7:0];
         if (bus.ce && bus.wr && bus.addr == 2'd2) m_en = bus.data_in[7:0];
      end
   endtask

   task automatic step();
      model_edge();
      @(posedge sys_clk);
      #1;
      drv_en = ~m_dir;
   endtask

   function automatic logic [31:0] expv(input logic [1:0] a);
      logic [7:0] v;
      v = a == 2'd0 ? m_dir : a == 2'd1 ? ((m_dir & m_out) | (~m_dir & m_deb)) :
          a == 2'd2 ? m_en : m_st;
      return {24'h0, v};
   endfunction

   task automatic wr(input logic [1:0] a, input logic [31:0] d);
      bus.ce = 1'b1; bus.wr = 1'b1; bus.addr = a; bus.data_in = d;
      step();
      bus.ce = 1'b0; bus.wr = 1'b0;
   endtask

   task automatic rd(input logic [1:0] a, input string n, input logic [7:0] mask = 8'h00);
      exp_t e;
      bus.ce = 1'b1; bus.wr = 1'b0; bus.addr = a; bus.data_in = $urandom;
      e.name = n; e.data = expv(a); e.irq = m_irq; e.mask = mask & m_dir; e.pins = m_out;
      sb.push_back(e);
      step();
      bus.ce = 1'b0;
   endtask

   always @(negedge sys_clk) begin
      if (bus.ce && !bus.wr) begin
         if (sb.size() == 0) begin
            checks++; errors++;
            $display("FAIL sb_empty: read with no expectation queued");
         end else begin
            mon_e = sb.pop_front();
            checks++;
            if (bus.data_out !== mon_e.data) begin
               errors++;
               $display("FAIL %s data: got %h want %h", mon_e.name, bus.data_out, mon_e.data);
            end
            checks++;
            if (irq !== mon_e.irq) begin
               errors++;
               $display("FAIL %s irq: got %b want %b", mon_e.name, irq, mon_e.irq);
            end
            if (mon_e.mask != 8'h00) begin
               checks++;
               if ((port_io & mon_e.mask) !== (mon_e.pins & mon_e.mask)) begin
                  errors++;
                  $display("FAIL %s pins: got %h want %h (mask %h)", mon_e.name,
                           port_io & mon_e.mask, mon_e.pins & mon_e.mask, mon_e.mask);
               end
            end
         end
      end
   end

   initial begin
      bus.ce = 1'b0; bus.wr = 1'b0; bus.addr = 2'd0; bus.data_in = 32'h0;
      step();
      wr(2'd0, 32'hFF);
      rd(2'd0, "rst_dir"); rd(2'd1, "rst_data"); rd(2'd2, "rst_en"); rd(2'd3, "rst_status");
      rst_sync = 1'b1;
      repeat (8) rd(2'd1, "rst_release_data");
      wr(2'd0, 32'hFFFF_FFFF);
      rd(2'd0, "dir_width");
      wr(2'd0, 32'hF0); wr(2'd1, 32'hA5); drv = 8'h03;
      repeat (8) step();
      rd(2'd1, "drive_data", 8'hF0);
      wr(2'd0, 32'h0); wr(2'd1, 32'h0); drv = 8'h00;
      repeat (8) step();
      wr(2'd2, 32'h01);
      drv[0] = 1'b1;
      repeat (3) rd(2'd1, "glitch_data");
      drv[0] = 1'b0;
      repeat (8) rd(2'd3, "glitch_status");
      drv[0] = 1'b1;
      repeat (8) rd(2'd1, "debounce_data");
      rd(2'd3, "irq_status"); rd(2'd3, "irq_level");
      wr(2'd3, 32'h01);
      rd(2'd3, "w1c_status"); rd(2'd3, "w1c_irq");
      drv[0] = 1'b0;
      repeat (8) rd(2'd3, "fall_status");
      drv[0] = 1'b1;
      repeat (5) step();
      wr(2'd3, 32'h01);
      rd(2'd3, "collide_status"); rd(2'd3, "collide_irq");
      for (int n = 0; n < 600; n++) begin
         case ($urandom_range(0, 9))
            0, 1: wr(2'($urandom_range(0, 3)), $urandom);
            2, 3, 4: rd(2'($urandom_range(0, 3)), "rand", 8'hFF);
            5: drv = 8'($urandom);
            6: drv[$urandom_range(0, 7)] ^= 1'b1;
            7: repeat ($urandom_range(1, 8)) step();
            8: if ($urandom_range(0, 7) == 0) begin
                  rst_sync = 1'b0;
                  wr(2'($urandom_range(0, 3)), $urandom);
                  rst_sync = 1'b1;
               end
            default: step();
         endcase
      end
      repeat (2) step();
      if (sb.size() != 0) begin
         errors++;
         $display("FAIL sb_drain: %0d expectations left, want 0", sb.size());
      end
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule

// File: doc/gpio_port.md
Name: gpio_port

Overview:
Parametrised bidirectional GPIO peripheral for the MIPS microcontroller; replaces the fixed 32-bit port_io pass-through. Per-pin direction control, 2-FF input synchronisation, per-pin debounce counter, rising-edge capture with maskable interrupt. Sits on the uC data-memory bus as a 4-register peripheral; drives the external port_io pins.

Parameters:
WIDTH, 32, number of GPIO pins (1..32); register bits at and above WIDTH read 0 and ignore writes.
DEBOUNCE_CYCLES, 4, consecutive stable sysclk cycles needed to accept a new input level (>=1).

Ports:
sys_clk  input  1  system clock; all state on rising edge
rst_sync  input  1  synchronous reset, active-low (0 = reset)
ce  input  1  chip enable from the address decoder
wr  input  1  1 = write, 0 = read; qualified by ce
addr  input  2  register select: 0 DIR, 1 DATA, 2 IRQ_EN, 3 IRQ_STATUS
data_in  input  32  write data
data_out  output  32  read data (combinational)
port_io  inout  WIDTH  external pins
irq  output  1  registered interrupt request

Behaviour:
- Reset (rst_sync=0 at a clock edge): DIR=0 (all inputs, port_io all Z), out_reg=0, IRQ_EN=0, IRQ_STATUS=0, sync FFs=0, debounced=0, all counters=0, irq=0. data_out=0 when ce=0. Reset overrides any concurrent bus write.
- Pin drive: port_io[i] = out_reg[i] when DIR[i]=1, else Z.
- Writes (ce=1, wr=1) take effect at the clock edge: addr 0 loads DIR; addr 1 loads out_reg; addr 2 loads IRQ_EN; addr 3 clears IRQ_STATUS bits where data_in=1 (W1C).
- Reads (ce=1, wr=0), combinational: addr 0 DIR; addr 1 per bit DIR[i] ? out_reg[i] : debounced[i]; addr 2 IRQ_EN; addr 3 IRQ_STATUS. ce=0 -> data_out=0.
- Input path, every pin regardless of DIR: port_io -> sync1 -> sync2.
- Debounce per bit: sync2==debounced -> counter=0. Otherwise counter increments; on the edge where counter==DEBOUNCE_CYCLES-1, debounced<=sync2 and counter<=0. A level must differ from debounced for DEBOUNCE_CYCLES consecutive edges. Shorter glitches are ignored and the counter restarts. Counter width = clog2(DEBOUNCE_CYCLES)+1; no wrap possible.
- Latency: a clean pin change is visible in DATA after 2+DEBOUNCE_CYCLES edges.
- Edge capture: on the edge where debounced[i] goes 0->1 with DIR[i]=0 and IRQ_EN[i]=1, IRQ_STATUS[i]<=1. Falling edges are never captured. Bits with DIR=1 or IRQ_EN=0 never set.
- Simultaneous set and W1C clear of the same bit: set wins (bit stays 1).
- Writing IRQ_EN=0 does not clear pending status bits.
- irq <= |(IRQ_STATUS & IRQ_EN), registered: irq asserts one cycle after the status bit sets and deasserts one cycle after the clear.
- DIR change 1->0: debounced keeps its last value. The pin must then settle through the debounce path. No spurious capture unless debounced actually rises afterwards.
- Reset mid-debounce: counters and debounced return to 0. A pin held high after reset yields a fresh rising edge after 2+DEBOUNCE_CYCLES edges. That edge is captured only if IRQ_EN was rewritten.

Test Plan:
- Reset: hold rst_sync=0 for 3 edges with port_io[3:0]=4'b1111 driven by bench -> all reads 0, irq=0, port_io not driven by DUT; release -> DATA[3:0]=4'b1111 after 2+4=6 edges.
- Output drive (WIDTH=8): write DIR=8'hF0, DATA=8'hA5 -> port_io[7:4]=4'hA, [3:0]=Z; read DATA with pins[3:0]=4'h3 stable -> 8'hA3.
- Debounce: pin0 pulses high 3 cycles -> DATA[0] stays 0, IRQ_STATUS=0; pin0 high 4+ cycles -> DATA[0]=1 exactly 6 edges after the pin change.
- Interrupt: IRQ_EN=8'h01, pin0 0->1 -> IRQ_STATUS=8'h01, irq=1 one cycle later; write 8'h01 to addr 3 -> status 0, irq drops next cycle; pin0 1->0 -> no status.
- Set/clear collision: W1C of bit0 issued on the same edge debounced[0] rises -> IRQ_STATUS[0]=1, irq stays/asserts 1.
- Width limit: WIDTH=8, write 32'hFFFF_FFFF to DIR -> read DIR=32'h0000_00FF.
